snn_debug_frame_tx: RTL and testbench
=====================================

// Module: snn_debug_frame_tx
// PURPOSE
//  Readout transmitter for the two-layer delayed-SNN debug taps. On a trigger it
//  snapshots all membrane potentials plus both layers' output spikes. It streams
//  them as a fixed byte frame over a valid/ready byte port toward the narrow chip IO.
//  It sits beside the network top and consumes its membrane_potential_out and spike outputs.
// PARAMETERS
//  N1   8   neurons in layer 1
//  N2   2   neurons in layer 2
//  W    2   bits per membrane potential
//  HDR  8'hA5  frame header byte
//  Derived: S = (N1+N2)*W + N1 + N2 snapshot bits; P = ceil(S/8) payload bytes; frame = P+2 bytes
// PORTS
//  clk                 in   1          system clock
//  reset               in   1          asynchronous reset, active high
//  enable              in   1          gates acceptance of new triggers only
//  trigger             in   1          snapshot request, sampled each clk
//  membrane_potential_in in (N1+N2)*W  layer1 in low N1*W bits, layer2 above
//  spikes_layer1_in    in   N1         layer-1 output spikes
//  spikes_layer2_in    in   N2         layer-2 output spikes
//  tx_data             out  8          current frame byte
//  tx_valid            out  1          tx_data valid
//  tx_ready            in   1          sink accepts byte when tx_valid&tx_ready
//  busy                out  1          frame in progress
//  overrun             out  1          sticky: trigger dropped while busy
//  frame_count         out  8          completed frames, wraps 255->0
// BEHAVIOUR
//  - Reset: tx_data=0, tx_valid=0, busy=0, overrun=0, frame_count=0, snapshot=0, FSM=IDLE.
//    Asserting reset mid-frame aborts the frame immediately; no partial resume.
//  - Snapshot packing, S bits: [N1*W+N2*W-1:0]=membrane_potential_in, next N1 bits=spikes_layer1_in,
//    top N2 bits=spikes_layer2_in. Zero-pad to P*8 bits.
//  - Frame: HDR, payload bytes LSB-first (byte0 = snapshot[7:0]), then CHK = XOR of the P payload bytes.
//    CHK excludes HDR.
//  - FSM IDLE -> SEND -> IDLE; byte index counter 0..P+1.
//    IDLE: trigger&enable at edge k latches the snapshot from inputs at edge k.
//    The same edge sets busy=1, tx_valid=1 and tx_data=HDR (1-cycle latency from trigger).
//    SEND: on each handshake the index increments and tx_data loads the next byte on the same edge.
//    tx_valid remains high between bytes (no bubbles). tx_data/tx_valid hold while tx_valid&!tx_ready.
//    After CHK handshake: frame_count+1 (wraps), busy=0, tx_valid=0 -> IDLE.
//  - Back-to-back: trigger&enable on the same edge as the CHK handshake starts a new frame.
//    The snapshot is re-latched, tx_valid stays 1, and tx_data=HDR next. This is not an overrun.
//  - Trigger while busy (other than the CHK-handshake edge): ignored, overrun<=1.
//    The in-flight snapshot is unchanged. overrun clears only on reset.
//  - enable low: no new frames. enable low mid-frame does not stop the current frame.
//    Trigger with enable low in IDLE is ignored and does not set overrun.
//  - Inputs change freely during SEND; only the latched snapshot is transmitted.
// TESTING (N1=8,N2=2,W=2: S=30,P=4, 6-byte frame)
//  1 Reset, then check all outputs: tx_valid=0, busy=0, overrun=0, frame_count=0.
//  2 mem=20'hABCDE, L1=8'h5A, L2=2'b11, 1-cycle trigger, tx_ready=1.
//    Expect A5,DE,BC,AA,35,FD on 6 consecutive cycles, then busy=0 and frame_count=1.
//  3 Same stimulus with tx_ready toggled 1/0 pseudo-randomly.
//    Expect an identical byte sequence, tx_data stable while stalled, and inputs changed mid-frame ignored.
//  4 Trigger mid-frame -> overrun=1, current frame unchanged.
//    Trigger on the CHK handshake edge -> second frame starts with no tx_valid gap, overrun unchanged.
//  5 Assert reset after byte 2 -> tx_valid=0 at once.
//    New trigger -> frame restarts at A5. Run 256 frames -> frame_count wraps to 0.
//  6 enable=0 with trigger pulses -> no frame and overrun stays 0.
//    Drop enable during SEND -> frame still completes.

Source files
------------

// File: rtl/snn_debug_frame_tx.sv
// Debug readout transmitter: snapshots the SNN membrane potentials and
// both layers' output spikes on a trigger and streams them as a fixed
// byte frame (HDR, payload LSB-first, XOR checksum) over a valid/ready port.
module snn_debug_frame_tx #(
  parameter int unsigned N1  = 8,
  parameter int unsigned N2  = 2,
  parameter int unsigned W   = 2,
  parameter logic [7:0]  HDR = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  trigger,
  input  logic [(N1+N2)*W-1:0]  membrane_potential_in,
  input  logic [N1-1:0]         spikes_layer1_in,
  input  logic [N2-1:0]         spikes_layer2_in,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic [7:0]            frame_count
);

  localparam int unsigned S      = (N1 + N2) * W + N1 + N2;
  localparam int unsigned P      = (S + 7) / 8;
  localparam int unsigned SNAP_W = P * 8;
  localparam int unsigned IDX_W  = $clog2(P + 2);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t             state, state_n;
  logic [SNAP_W-1:0]  snapshot, snapshot_n, snap_in;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [7:0]         tx_data_n, frame_count_n;
  logic               tx_valid_n, busy_n, overrun_n;
  logic [7:0]         chk, next_byte;
  logic               start, handshake, last;

  // Pack spikes above the membrane potentials, zero-padded to whole bytes.
  assign snap_in   = SNAP_W'({spikes_layer2_in, spikes_layer1_in, membrane_potential_in});
  assign start     = trigger & enable;
  assign handshake = tx_valid & tx_ready;
  assign last      = (idx == IDX_W'(P + 1));

  // Checksum over the latched payload bytes (header excluded).
  always_comb begin
    chk = '0;
    for (int unsigned i = 0; i < P; i++) begin
      chk = chk ^ snapshot[i*8 +: 8];
    end
  end

  // Byte that follows frame index idx: payload[idx] for idx < P, else checksum.
  always_comb begin
    next_byte = chk;
    for (int unsigned i = 0; i < P; i++) begin
      if (32'(idx) == i) next_byte = snapshot[i*8 +: 8];
    end
  end

  // Next-state and output-register logic for the framing FSM.
  always_comb begin
    state_n       = state;
    snapshot_n    = snapshot;
    idx_n         = idx;
    tx_data_n     = tx_data;
    tx_valid_n    = tx_valid;
    busy_n        = busy;
    overrun_n     = overrun;
    frame_count_n = frame_count;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = SEND;
          snapshot_n = snap_in;
          idx_n      = '0;
          tx_data_n  = HDR;
          tx_valid_n = 1'b1;
          busy_n     = 1'b1;
        end
      end
      SEND: begin
        if (handshake && last) begin
          frame_count_n = frame_count + 8'd1;
          idx_n         = '0;
          // A trigger on the checksum handshake chains straight into a new frame.
          if (start) begin
            snapshot_n = snap_in;
            tx_data_n  = HDR;
          end else begin
            state_n    = IDLE;
            tx_valid_n = 1'b0;
            busy_n     = 1'b0;
          end
        end else begin
          if (start) overrun_n = 1'b1;
          if (handshake) begin
            idx_n     = idx + IDX_W'(1);
            tx_data_n = next_byte;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      snapshot    <= '0;
      idx         <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      snapshot    <= snapshot_n;
      idx         <= idx_n;
      tx_data     <= tx_data_n;
      tx_valid    <= tx_valid_n;
      busy        <= busy_n;
      overrun     <= overrun_n;
      frame_count <= frame_count_n;
    end
  end

endmodule

// File: tb/tb_snn_debug_frame_tx.sv
// Directed testbench for snn_debug_frame_tx (N1=8, N2=2, W=2: 6-byte frames).
module tb_snn_debug_frame_tx;

  logic        clk = 1'b0;
  logic        reset, enable, trigger, tx_ready;
  logic [19:0] membrane_potential;
  logic [7:0]  spikes_l1;
  logic [1:0]  spikes_l2;
  logic [7:0]  tx_data, frame_count;
  logic        tx_valid, busy, overrun;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  got [6];
  logic [7:0]  frame_a [6] = '{8'hA5, 8'hDE, 8'hBC, 8'hAA, 8'h35, 8'hFD};
  logic [7:0]  frame_b [6] = '{8'hA5, 8'h45, 8'h23, 8'h31, 8'h1C, 8'h4B};
  int          cycles;
  logic [7:0]  fc;

  snn_debug_frame_tx #(.N1(8), .N2(2), .W(2), .HDR(8'hA5)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .enable                (enable),
    .trigger               (trigger),
    .membrane_potential_in (membrane_potential),
    .spikes_layer1_in      (spikes_l1),
    .spikes_layer2_in      (spikes_l2),
    .tx_data               (tx_data),
    .tx_valid              (tx_valid),
    .tx_ready              (tx_ready),
    .busy                  (busy),
    .overrun               (overrun),
    .frame_count           (frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", tag, actual, expected);
    end
  endtask

  task automatic set_a();
    membrane_potential = 20'hABCDE; spikes_l1 = 8'h5A; spikes_l2 = 2'b11;
  endtask

  task automatic set_b();
    membrane_potential = 20'h12345; spikes_l1 = 8'hC3; spikes_l2 = 2'b01;
  endtask

  // Called at a negedge: one-cycle trigger pulse, returns at the next negedge.
  task automatic start_frame();
    trigger = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trigger = 1'b0;
  endtask

  // Collect 6 handshaken bytes; optional random stalls, input scrambling,
  // and a retrigger on the checksum handshake edge.
  task automatic run_frame(input bit stall, input bit scramble, input bit retrig, output int ncyc);
    int n = 0;
    bit have_prev = 1'b0;
    logic [7:0] prev = '0;
    ncyc = 0;
    while (n < 6 && ncyc < 200) begin
      tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (have_prev) begin
        check("stall_hold_data", tx_data, prev);
        check("stall_hold_valid", tx_valid, 1);
      end
      have_prev = 1'b0;
      if (tx_valid && tx_ready) begin
        got[n] = tx_data;
        n++;
      end else if (tx_valid) begin
        have_prev = 1'b1;
        prev = tx_data;
      end
      if (retrig && n == 6) begin
        set_b();
        trigger = 1'b1;
      end else if (scramble && n >= 1) begin
        membrane_potential = 20'($urandom);
        spikes_l1 = 8'($urandom);
        spikes_l2 = 2'($urandom);
      end
      @(negedge clk);
      ncyc++;
    end
    trigger = 1'b0;
    tx_ready = 1'b1;
    if (n < 6) check("frame_timeout_bytes", n, 6);
  endtask

  task automatic check_frame(input string prefix, input bit use_b);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_byte%0d", prefix, i), got[i], use_b ? frame_b[i] : frame_a[i]);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; trigger = 1'b0; tx_ready = 1'b1;
    set_a();
    fc = 8'd0;
    repeat (2) @(negedge clk);
    // 1: reset state
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_tx_data", tx_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // 2: basic frame, sink always ready
    start_frame();
    run_frame(1'b0, 1'b0, 1'b0, cycles);
    check_frame("t2", 1'b0);
    check("t2_cycles", cycles, 6);
    fc++;
    check("t2_busy_after", busy, 0);
    check("t2_valid_after", tx_valid, 0);
    check("t2_frame_count", frame_count, fc);

    // 3: random stalls, inputs scrambled mid-frame, back-to-back retrigger on CHK
    set_a();
    start_frame();
    run_frame(1'b1, 1'b1, 1'b1, cycles);
    check_frame("t3", 1'b0);
    fc++;
    check("t3_b2b_valid", tx_valid, 1);
    check("t3_b2b_hdr", tx_data, 8'hA5);
    check("t3_b2b_busy", busy, 1);
    check("t3_b2b_overrun", overrun, 0);
    check("t3_b2b_frame_count", frame_count, fc);
    run_frame(1'b1, 1'b0, 1'b0, cycles);
    check_frame("t3b", 1'b1);
    fc++;
    check("t3b_frame_count", frame_count, fc);
    check("t3b_overrun", overrun, 0);

    // 4: trigger mid-frame sets overrun and leaves the in-flight snapshot alone
    set_a();
    tx_ready = 1'b0;
    start_frame();
    set_b();
    start_frame();
    check("t4_overrun", overrun, 1);
    check("t4_hold_hdr", tx_data, 8'hA5);
    check("t4_busy", busy, 1);
    run_frame(1'b0, 1'b0, 1'b0, cycles);
    check_frame("t4", 1'b0);
    fc++;
    check("t4_frame_count", frame_count, fc);
    check("t4_overrun_sticky", overrun, 1);

    // 5: reset after two bytes aborts at once; restart; frame_count wrap
    set_a();
    start_frame();
    check("t5_byte0", tx_data, 8'hA5);
    @(negedge clk);
    check("t5_byte1", tx_data, 8'hDE);
    @(negedge clk);
    check("t5_byte2", tx_data, 8'hBC);
    reset = 1'b1;
    #1;
    check("t5_rst_valid", tx_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_overrun", overrun, 0);
    check("t5_rst_frame_count", frame_count, 0);
    @(negedge clk);
    reset = 1'b0;
    fc = 8'd0;
    @(negedge clk);
    start_frame();
    run_frame(1'b0, 1'b0, 1'b0, cycles);
    check_frame("t5", 1'b0);
    fc++;
    for (int i = 0; i < 254; i++) begin
      start_frame();
      run_frame(1'b0, 1'b0, 1'b0, cycles);
      fc++;
    end
    check("t5_frame_count_255", frame_count, 8'hFF);
    start_frame();
    run_frame(1'b0, 1'b0, 1'b0, cycles);
    fc++;
    check("t5_frame_count_wrap", frame_count, 0);
    check("t5_fc_model", fc, 0);

    // 6: enable low blocks new frames without overrun; dropping it mid-frame is harmless
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_frame();
      check($sformatf("t6_idle_valid%0d", i), tx_valid, 0);
      check($sformatf("t6_idle_busy%0d", i), busy, 0);
    end
    check("t6_overrun", overrun, 0);
    check("t6_frame_count", frame_count, fc);
    enable = 1'b1;
    set_b();
    start_frame();
    enable = 1'b0;
    run_frame(1'b0, 1'b0, 1'b0, cycles);
    check_frame("t6", 1'b1);
    fc++;
    check("t6_frame_count_after", frame_count, fc);
    check("t6_busy_after", busy, 0);
    check("t6_overrun_after", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
